fpu_issue_ctrl: RTL

//  Consumes decoded FP control strobes (is_adsb/is_sub/is_mult/is_load/reg_write) and issues them.

---
 rtl/fpu_issue_ctrl_if.sv | 42 ++++
 rtl/fpu_issue_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Handshake and write-back bundle between the FP decoder/execution units
// and the FP issue controller.
interface fpu_issue_ctrl_if;
    // Decoder side
    logic       dec_valid;
    logic       dec_ready;
    logic       reg_write;
    logic       is_adsb;
    logic       is_sub;
    logic       is_mult;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    // Execution units and load return
    logic       load_done;
    logic       add_start;
    logic       add_sub;
    logic       mul_start;
    // Register-file write-back and status
    logic       wb_en;
    logic [4:0] wb_rd;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       busy;

    // Environment: decoder, memory return path, execution units
    modport master (
        output dec_valid, reg_write, is_adsb, is_sub, is_mult, is_load,
               rs1, rs2, rd, load_done,
        input  dec_ready, add_start, add_sub, mul_start,
               wb_en, wb_rd, wb_sel, illegal, busy
    );

    // Issue controller
    modport slave (
        input  dec_valid, reg_write, is_adsb, is_sub, is_mult, is_load,
               rs1, rs2, rd, load_done,
        output dec_ready, add_start, add_sub, mul_start,
               wb_en, wb_rd, wb_sel, illegal, busy
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: RAW/WAW interlock through a 32-entry pending
// scoreboard, single write-port reservation ring for adder/multiplier
// results, one outstanding load with a one-entry return buffer.
// Optional feature: define FPU_STALL_CNT_EN to add the stall_cnt port,
// a saturating count of cycles with dec_valid & !dec_ready.
module fpu_issue_ctrl #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            rstn,
`ifdef FPU_STALL_CNT_EN
    output logic [31:0]     stall_cnt,
`endif
    fpu_issue_ctrl_if.slave io
);

    localparam int DEPTH = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_ADD  = 2'b01,
        SEL_MUL  = 2'b10,
        SEL_LOAD = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        wb_sel_e    sel;
    } slot_t;

    // ring_q[k] retires k cycles from now; ring_q[0] is the head
    slot_t       ring_q [DEPTH];
    slot_t       ring_d [DEPTH];
    logic [31:0] pend_q, pend_d;
    logic        load_pending_q;
    logic        load_buf_q;
    logic [4:0]  load_rd_q;

    logic [DEPTH:0] occ;
    logic op_add, op_mul, op_ld, op_ill;
    logic arith_haz, stall, dec_ready, accept;
    logic load_take, load_avail, load_wb;

    // Slot occupancy seen by a new op; index DEPTH is always free
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        occ = '0;
        for (int k = 0; k < DEPTH; k++) occ[k] = ring_q[k].valid;
    end

    // Classify the presented op; loads take priority, then multiply, then add/sub
    always_comb begin
        op_ld     = io.reg_write & io.is_load;
        op_mul    = io.reg_write & ~io.is_load & io.is_mult;
        op_add    = io.reg_write & ~io.is_load & ~io.is_mult & io.is_adsb;
        op_ill    = io.reg_write & ~io.is_load & ~io.is_mult & ~io.is_adsb;
        arith_haz = pend_q[io.rs1] | pend_q[io.rs2] | pend_q[io.rd];
        stall     = (op_add & (arith_haz | occ[ADD_LAT]))
                  | (op_mul & (arith_haz | occ[MUL_LAT]))
                  | (op_ld  & (pend_q[io.rd] | load_pending_q));
        dec_ready = ~(io.dec_valid & stall);
        accept    = io.dec_valid & dec_ready;
    end

    assign io.dec_ready = dec_ready;
    assign io.add_start = accept & op_add;
    assign io.add_sub   = accept & op_add & io.is_sub;
    assign io.mul_start = accept & op_mul;
    assign io.illegal   = accept & op_ill;
    assign io.busy      = (|pend_q) | load_pending_q;

    // Write-port arbitration: arithmetic head always wins over load data
    always_comb begin
        load_take  = io.load_done & load_pending_q & ~load_buf_q;
        load_avail = load_buf_q | load_take;
        io.wb_en   = 1'b0;
        io.wb_rd   = '0;
        io.wb_sel  = SEL_NONE;
        load_wb    = 1'b0;
        if (ring_q[0].valid) begin
            io.wb_en  = 1'b1;
            io.wb_rd  = ring_q[0].rd;
            io.wb_sel = ring_q[0].sel;
        end else if (load_avail) begin
            io.wb_en  = 1'b1;
            io.wb_rd  = load_rd_q;
            io.wb_sel = SEL_LOAD;
            load_wb   = 1'b1;
        end
    end

    // Next ring: shift toward the head, then book the accepted op's slot
    always_comb begin
        for (int k = 0; k < DEPTH - 1; k++) ring_d[k] = ring_q[k + 1];
        ring_d[DEPTH - 1] = '0;
        if (accept && op_add) ring_d[ADD_LAT - 1] = '{valid: 1'b1, rd: io.rd, sel: SEL_ADD};
        if (accept && op_mul) ring_d[MUL_LAT - 1] = '{valid: 1'b1, rd: io.rd, sel: SEL_MUL};
    end

    // Next scoreboard: retire the written register, then mark the new destination
    always_comb begin
        pend_d = pend_q;
        if (io.wb_en) pend_d[io.wb_rd] = 1'b0;
        if (accept && (op_add || op_mul || op_ld)) pend_d[io.rd] = 1'b1;
    end

    // State registers; reset drops every in-flight write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the ring is reset entry by entry; a stale valid bit would write back after reset.
            for (int k = 0; k < DEPTH; k++) ring_q[k] <= '0;
            pend_q         <= '0;
            load_pending_q <= 1'b0;
            load_buf_q     <= 1'b0;
            load_rd_q      <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            for (int k = 0; k < DEPTH; k++) ring_q[k] <= ring_d[k];
            pend_q     <= pend_d;
            load_buf_q <= load_avail & ~load_wb;
            if (accept && op_ld) begin
                load_pending_q <= 1'b1;
                load_rd_q      <= io.rd;
            end else if (load_wb) begin
                load_pending_q <= 1'b0;
            end
        end
    end

`ifdef FPU_STALL_CNT_EN
    // Saturating count of cycles in which a presented op was held off
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (io.dec_valid && !dec_ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
